// File: rtl/pulse_arb_pkg.sv
// Shared definitions for the pulse arbiter: FSM state width and encodings.
package pulse_arb_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/pulse_sync_edge.sv
// Per-requester front end: 2-flop synchronizer followed by a registered
// rising-edge detector.
// Ports:
//   Clock   - system clock
//   Resetn  - async active-low reset, clears every flop
//   pulse_i - raw asynchronous request level
//   edge_o  - one-cycle pulse per low-to-high transition of the synced level,
//             three clocks after pulse_i is first sampled high
module pulse_sync_edge (
  input  logic Clock,
  input  logic Resetn,
  input  logic pulse_i,
  output logic edge_o
);
  logic sync1_q, sync2_q, prev_q, edge_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= pulse_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // Cleared prev_q means a level already high at reset release counts as one edge.
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;
endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter for N pulse requesters sharing one resource.
// Each press latches a pending bit; an IDLE/START/WAIT FSM grants one
// requester at a time, strobes o_start, and waits for i_done.
// Ports:
//   Clock, Resetn - system clock, async active-low reset
//   i_pulse[N]    - raw asynchronous request levels
//   i_done        - resource completion strobe, honoured only in WAIT
//   o_start       - one-cycle launch strobe (START state)
//   o_grant[N]    - one-hot grant, held through START and WAIT
//   o_grant_id    - binary index of the grant, zero in IDLE
//   o_busy        - high in START and WAIT
//   o_pending[N]  - latched requests not yet served
module pulse_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [N-1:0]  i_pulse,
  input  logic          i_done,
  output logic          o_start,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_id,
  output logic          o_busy,
  output logic [N-1:0]  o_pending
);
  logic [N-1:0]  edge_w;
  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d, clr;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] id_q, id_d, ptr_q, ptr_d, win_id;

  for (genvar g = 0; g < N; g++) begin : g_sync
    pulse_sync_edge u_sync (
      .Clock  (Clock),
      .Resetn (Resetn),
      .pulse_i(i_pulse[g]),
      .edge_o (edge_w[g])
    );
  end

  // Scan from ptr+N (= ptr itself) down to ptr+1 so the nearest index after
  // ptr overwrites farther ones; ptr only wins when it is the sole request.
  always_comb begin
    win_id = ptr_q;
    for (int off = N; off >= 1; off--) begin
      if (pending_q[(int'(ptr_q) + off) % N]) win_id = IW'((int'(ptr_q) + off) % N);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d         = START;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          id_d            = win_id;
          clr[win_id]     = 1'b1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (i_done) begin
          state_d = IDLE;
          ptr_d   = id_q;
          grant_d = '0;
          id_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
    // A fresh edge beats the grant's clear, so a re-press is never lost.
    pending_d = (pending_q & ~clr) | edge_w;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= IW'(N - 1);  // search starts at index 0 after reset
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign o_start    = (state_q == START);
  assign o_busy     = (state_q != IDLE);
  assign o_grant    = grant_q;
  assign o_grant_id = id_q;
  assign o_pending  = pending_q;
endmodule

// File: tb/tb_pulse_arbiter.sv
module tb_pulse_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic [N-1:0]  i_pulse = '0;
  logic          i_done = 1'b0;
  logic          o_start;
  logic [N-1:0]  o_grant;
  logic [IW-1:0] o_grant_id;
  logic          o_busy;
  logic [N-1:0]  o_pending;

  int checks = 0;
  int errors = 0;

  pulse_arbiter #(.N(N), .IW(IW)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .i_pulse   (i_pulse),
    .i_done    (i_done),
    .o_start   (o_start),
    .o_grant   (o_grant),
    .o_grant_id(o_grant_id),
    .o_busy    (o_busy),
    .o_pending (o_pending)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] pulse;
    logic         done;
    logic         start;
    logic [N-1:0] grant;
    logic [IW-1:0] id;
    logic         busy;
    logic [N-1:0] pend;
  } vec_t;

  vec_t tbl[$];
  int   seq[$];

  function automatic vec_t mk(logic r, logic [N-1:0] p, logic d, logic s,
                              logic [N-1:0] g, logic [IW-1:0] id, logic b,
                              logic [N-1:0] pe);
    vec_t v;
    v.rst_n = r; v.pulse = p; v.done = d; v.start = s;
    v.grant = g; v.id = id; v.busy = b; v.pend = pe;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic s, input logic [N-1:0] g,
                          input logic [IW-1:0] id, input logic b, input logic [N-1:0] pe);
    chk({tag, " start"}, 32'(o_start), 32'(s));
    chk({tag, " grant"}, 32'(o_grant), 32'(g));
    chk({tag, " id"},    32'(o_grant_id), 32'(id));
    chk({tag, " busy"},  32'(o_busy), 32'(b));
    chk({tag, " pend"},  32'(o_pending), 32'(pe));
  endtask

  task automatic do_reset;
    Resetn = 1'b0; i_pulse = '0; i_done = 1'b0;
    step;
    Resetn = 1'b1;
  endtask

  task automatic press(input logic [N-1:0] p, input int hi);
    i_pulse = p;
    repeat (hi) step;
    i_pulse = '0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step;
      if (o_start) begin ok = 1'b1; break; end
    end
    chk({tag, " start seen"}, 32'(ok), 32'd1);
  endtask

  // Auto-respond with i_done while in WAIT, recording every granted id.
  task automatic serve_cycles(input int n, input logic fair_press);
    logic onehot_ok = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (fair_press) i_pulse = ((c % 4) < 2) ? 4'b1001 : 4'b0000;
      i_done = o_busy & ~o_start;
      step;
      if ($countones(o_grant) > 1) onehot_ok = 1'b0;
      if (o_start) seq.push_back(int'(o_grant_id));
    end
    i_pulse = '0; i_done = 1'b0;
    chk("grant onehot", 32'(onehot_ok), 32'd1);
  endtask

  initial begin
    // Single press on requester 2, held 10 cycles.
    tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0100));
    tbl.push_back(mk(1, 4'b0100, 0, 1, 4'b0100, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b0100, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 4'b0000, 0, 0, 4'b0000));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0, 4'b0000));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000));
    // Reset, then all four pressed together; done in START is ignored.
    tbl.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b1111));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 4'b0001, 0, 1, 4'b1110));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0001, 0, 1, 4'b1110));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b1110));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 4'b0010, 1, 1, 4'b1100));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0010, 1, 1, 4'b1100));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b1100));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 4'b0100, 2, 1, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0100, 2, 1, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b1000));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 4'b1000, 3, 1, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b1000, 3, 1, 4'b0000));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 0, 4'b0000));

    // Reset state before any clock edge.
    #2;
    chk_outs("reset", 0, 4'b0000, 0, 0, 4'b0000);
    step;
    Resetn = 1'b1;

    foreach (tbl[i]) begin
      Resetn  = tbl[i].rst_n;
      i_pulse = tbl[i].pulse;
      i_done  = tbl[i].done;
      step;
      chk_outs($sformatf("vec%0d", i), tbl[i].start, tbl[i].grant, tbl[i].id,
               tbl[i].busy, tbl[i].pend);
    end
    Resetn = 1'b1; i_pulse = '0; i_done = 1'b0;

    // Fairness: requesters 0 and 3 pressing continuously must alternate.
    seq.delete();
    serve_cycles(48, 1'b1);
    chk("fair count", 32'(seq.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++)
      chk($sformatf("fair grant%0d", k), (seq.size() > k) ? 32'(seq[k]) : 32'hFFFF,
          (k % 2) ? 32'd3 : 32'd0);

    // Re-press of requester 1 while it is being served.
    do_reset;
    press(4'b0010, 3);
    wait_start("repress", 10);
    chk("repress id", 32'(o_grant_id), 32'd1);
    press(4'b1010, 2);
    repeat (2) step;
    press(4'b0010, 2);
    repeat (4) step;
    chk("repress busy", 32'(o_busy), 32'd1);
    chk("repress grant", 32'(o_grant), 32'b0010);
    chk("repress pend", 32'(o_pending), 32'b1010);
    i_done = 1'b1;
    step;
    i_done = 1'b0;
    chk("repress idle", 32'(o_busy), 32'd0);
    seq.delete();
    serve_cycles(20, 1'b0);
    chk("repress count", 32'(seq.size()), 32'd2);
    chk("repress first", (seq.size() > 0) ? 32'(seq[0]) : 32'hFFFF, 32'd3);
    chk("repress second", (seq.size() > 1) ? 32'(seq[1]) : 32'hFFFF, 32'd1);

    // Asynchronous reset in WAIT with requests 1 and 3 pending.
    do_reset;
    press(4'b0001, 3);
    wait_start("areset", 10);
    chk("areset id0", 32'(o_grant_id), 32'd0);
    press(4'b1010, 2);
    repeat (4) step;
    chk("areset pend", 32'(o_pending), 32'b1010);
    chk("areset busy pre", 32'(o_busy), 32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    chk_outs("areset async", 0, 4'b0000, 0, 0, 4'b0000);
    step;
    Resetn = 1'b1;
    press(4'b1000, 3);
    wait_start("after reset", 10);
    chk("after reset id", 32'(o_grant_id), 32'd3);
    chk("after reset grant", 32'(o_grant), 32'b1000);
    chk("after reset pend", 32'(o_pending), 32'b0000);
    step;
    i_done = 1'b1;
    step;
    i_done = 1'b0;
    chk("after reset idle", 32'(o_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
